turbo_dispatch_sched: RTL

Packet dispatcher and in-order output sequencer for the turbo decoder bank. It sits between the clock-crossing input FIFO and the NUM_TURBO `bus2st_turbo` decoders. It pops WORDS_PER_PKT bus words per packet and steers them to a free decoder chosen round-robin. It records the dispatch order so the output mux drains decoders in packet order, and a decoder is released only once its output packet has drained.

---
 rtl/turbo_pkg.sv | 15 +
 rtl/turbo_dispatch_sched_rr_pick.sv | 29 ++
 rtl/turbo_dispatch_sched.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/turbo_pkg.sv
// Shared turbo-bank definitions: bank geometry and the dispatcher FSM state type.
// Also used by trb_out_mux and the turbo top level.
package turbo_pkg;

  localparam int unsigned NUM_TURBO     = 16;
  localparam int unsigned WORDS_PER_PKT = 25;
  localparam int unsigned TAG_W         = $clog2(NUM_TURBO);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PICK = 2'd1,
    XFER = 2'd2
  } sched_state_e;

endpackage

// File: rtl/turbo_dispatch_sched_rr_pick.sv
// rr_pick: combinational round-robin first-one finder.
// Scans elig_i upward from rr_ptr_i, wrapping modulo NUM_TURBO.
module rr_pick #(
  parameter int unsigned NUM_TURBO = turbo_pkg::NUM_TURBO,
  parameter int unsigned TAG_W     = turbo_pkg::TAG_W
) (
  input  logic [NUM_TURBO-1:0] elig_i,
  input  logic [TAG_W-1:0]     rr_ptr_i,
  output logic [TAG_W-1:0]     idx_o,
  output logic                 found_o
);

  logic [TAG_W-1:0] cand;

  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    cand    = '0;
    for (int unsigned i = 0; i < NUM_TURBO; i++) begin
      // NUM_TURBO is a power of two, so TAG_W-bit wrap is the modulo
      cand = rr_ptr_i + TAG_W'(i);
      if (!found_o && elig_i[cand]) begin
        idx_o   = cand;
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/turbo_dispatch_sched.sv
// turbo_dispatch_sched: round-robin packet dispatcher for the turbo decoder bank with in-order drain tags.
// Build option: define TURBO_SCHED_GAP_EN to limit in_rdreq to every second cycle.
module turbo_dispatch_sched #(
  parameter int unsigned NUM_TURBO     = turbo_pkg::NUM_TURBO,
  parameter int unsigned WORDS_PER_PKT = turbo_pkg::WORDS_PER_PKT,
  parameter int unsigned TAG_W         = turbo_pkg::TAG_W
) (
  input  logic                 clk_st,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_rdreq,
  input  logic [NUM_TURBO-1:0] dec_ready,
  output logic [NUM_TURBO-1:0] dec_en,
  output logic [TAG_W-1:0]     out_sel,
  output logic                 out_sel_valid,
  input  logic                 out_done,
  output logic [TAG_W:0]       busy_cnt,
  output logic                 err
);
  import turbo_pkg::*;

  localparam logic [7:0] LAST_WCNT = 8'(WORDS_PER_PKT - 1);

  sched_state_e           state_q, state_d;
  logic [NUM_TURBO-1:0]   busy_q, busy_d;
  logic [TAG_W-1:0]       rr_ptr_q, rr_ptr_d, cur_q, cur_d;
  logic [7:0]             wcnt_q, wcnt_d;
  logic [TAG_W-1:0]       tag_q [NUM_TURBO];
  logic [TAG_W-1:0]       tag_d [NUM_TURBO];
  logic [TAG_W-1:0]       head_q, head_d, tail_q, tail_d;
  logic [TAG_W:0]         cnt_q, cnt_d;
  logic                   rdreq_q, rdreq_d;
  logic [NUM_TURBO-1:0]   dec_en_q, dec_en_d;
  logic [TAG_W-1:0]       out_sel_q, out_sel_d;
  logic                   out_sel_valid_q, out_sel_valid_d;
  logic [TAG_W:0]         busy_cnt_q, busy_cnt_d;
  logic                   err_q, err_d;
  logic                   push, pop, issue_gate;
  logic [NUM_TURBO-1:0]   elig;
  logic [TAG_W-1:0]       pick_idx;
  logic                   pick_found;

  assign elig = ~busy_q & dec_ready;

  rr_pick #(
    .NUM_TURBO (NUM_TURBO),
    .TAG_W     (TAG_W)
  ) u_rr_pick (
    .elig_i   (elig),
    .rr_ptr_i (rr_ptr_q),
    .idx_o    (pick_idx),
    .found_o  (pick_found)
  );

`ifdef TURBO_SCHED_GAP_EN
  logic gate_q;
  always_ff @(posedge clk_st or posedge rst) begin
    if (rst) gate_q <= 1'b1;
    else     gate_q <= ~gate_q;
  end
  // rdreq is registered, so the decision made now must see the next cycle's phase
  assign issue_gate = ~gate_q;
`else
  assign issue_gate = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    rr_ptr_d = rr_ptr_q;
    cur_d    = cur_q;
    wcnt_d   = wcnt_q;
    tag_d    = tag_q;
    head_d   = head_q;
    tail_d   = tail_q;
    cnt_d    = cnt_q;
    rdreq_d  = 1'b0;
    err_d    = err_q;
    push     = 1'b0;
    pop      = 1'b0;

    case (state_q)
      IDLE: if (in_valid && (elig != '0)) state_d = PICK;
      PICK: begin
        if (pick_found) begin
          cur_d            = pick_idx;
          busy_d[pick_idx] = 1'b1;
          tag_d[tail_q]    = pick_idx;
          tail_d           = tail_q + 1'b1;
          push             = 1'b1;
          rr_ptr_d         = pick_idx + 1'b1;
          wcnt_d           = '0;
          state_d          = XFER;
          if (in_valid && dec_ready[pick_idx] && issue_gate) begin
            rdreq_d = 1'b1;
            wcnt_d  = 8'd1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      XFER: begin
        if (in_valid && dec_ready[cur_q] && issue_gate) begin
          rdreq_d = 1'b1;
          wcnt_d  = wcnt_q + 1'b1;
          if (wcnt_q == LAST_WCNT) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (out_done) begin
      if (cnt_q != '0) begin
        busy_d[tag_q[head_q]] = 1'b0;
        head_d = head_q + 1'b1;
        pop    = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end

    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (!push && pop) cnt_d = cnt_q - 1'b1;

    dec_en_d = '0;
    if (rdreq_q) dec_en_d[cur_q] = 1'b1;

    out_sel_d       = tag_d[head_d];
    out_sel_valid_d = (cnt_d != '0);

    busy_cnt_d = '0;
    for (int unsigned i = 0; i < NUM_TURBO; i++) begin
      busy_cnt_d = busy_cnt_d + (TAG_W+1)'(busy_d[i]);
    end
  end

  always_ff @(posedge clk_st or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      busy_q          <= '0;
      rr_ptr_q        <= '0;
      cur_q           <= '0;
      wcnt_q          <= '0;
      for (int unsigned i = 0; i < NUM_TURBO; i++) tag_q[i] <= '0;
      head_q          <= '0;
      tail_q          <= '0;
      cnt_q           <= '0;
      rdreq_q         <= 1'b0;
      dec_en_q        <= '0;
      out_sel_q       <= '0;
      out_sel_valid_q <= 1'b0;
      busy_cnt_q      <= '0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      busy_q          <= busy_d;
      rr_ptr_q        <= rr_ptr_d;
      cur_q           <= cur_d;
      wcnt_q          <= wcnt_d;
      tag_q           <= tag_d;
      head_q          <= head_d;
      tail_q          <= tail_d;
      cnt_q           <= cnt_d;
      rdreq_q         <= rdreq_d;
      dec_en_q        <= dec_en_d;
      out_sel_q       <= out_sel_d;
      out_sel_valid_q <= out_sel_valid_d;
      busy_cnt_q      <= busy_cnt_d;
      err_q           <= err_d;
    end
  end

  assign in_rdreq      = rdreq_q;
  assign dec_en        = dec_en_q;
  assign out_sel       = out_sel_q;
  assign out_sel_valid = out_sel_valid_q;
  assign busy_cnt      = busy_cnt_q;
  assign err           = err_q;

endmodule
